output_share_writeback: RTL and testbench
=========================================

Name: output_share_writeback

Overview:
- Writeback engine for the accelerator: drains a finished result tile from the output buffer SRAM into the shared SRAM, starting at base address OADDR.
- Runs after the compute controller's OUTPUT phase. It is the reader of the output buffer and the writer of the share memory.
- Mirrors the load path, which moves data share -> weight/activate.
- One word per cycle when EN stays high.

Parameters:
ADDR_W, 13, address width of output buffer and share memory
DATA_W, 16, data word width
WORDS, 31, words per tile; output buffer addresses 0..WORDS-1

Ports:
CLK  input  1  clock
RESET  input  1  asynchronous active-high reset
EN  input  1  global enable; gates START acceptance and read issue
START  input  1  begin a transfer; sampled only in IDLE with EN=1
OADDR  input  ADDR_W  share base address; latched on accepted START
STATE  output  3  current state encoding
BUSY  output  1  high in every state except IDLE
DONE  output  1  one-cycle pulse after the last share write
output_cen  output  1  output buffer chip enable, active-low
output_wen  output  1  output buffer write enable, active-low; constant 1
output_ren  output  1  output buffer read enable, active-high
output_addr  output  ADDR_W  output buffer read address
output_rdata  input  DATA_W  output buffer read data, valid 1 cycle after output_cen=0 is presented
share_cen  output  1  share chip enable, active-low
share_wen  output  1  share write enable, active-low
share_ren  output  1  share read enable; constant 0
share_addr  output  ADDR_W  share write address
share_wdata  output  DATA_W  share write data

Behaviour:
- Outputs: all registered.
- Reset values:
  - STATE=0, BUSY=0, DONE=0
  - output_cen=1, output_wen=1, output_ren=0, output_addr=0
  - share_cen=1, share_wen=1, share_ren=0, share_addr=0, share_wdata=0
  - Internal counters and base register cleared.
- Reset mid-operation: abort immediately, drop in-flight read/write, return to IDLE. No partial DONE.
- States:
  - IDLE=0: on START&EN, latch base=OADDR, clear rd_cnt/wr_cnt, go STREAM.
  - STREAM=1:
    - Each EN=1 cycle: present output_cen=0, output_ren=1, output_addr=rd_cnt, then rd_cnt++.
    - EN=0: output_cen=1, output_ren=0, rd_cnt holds.
    - Leave for FLUSH after read WORDS-1 has been presented.
  - FLUSH=2: output_cen=1. Wait until no read is in flight and the write stage is empty, then go FINISH.
  - FINISH=3: DONE=1 for exactly one cycle, then IDLE.
- Write stage:
  - Each returned read word is captured unconditionally, regardless of EN. No data loss on stall.
  - Next cycle: share_cen=0, share_wen=0, share_addr=base+wr_cnt, share_wdata=word; wr_cnt++.
  - Otherwise share_cen=1, share_wen=1.
- Addressing: share_addr sum is modulo 2^ADDR_W, so it wraps silently past 0x1FFF.
- Latency:
  - START sampled in cycle C0: first read presented C1, first share write C3.
  - With no stalls, last write at C(WORDS+2). DONE at C(WORDS+3), i.e. C34 for WORDS=31.
  - Back in IDLE at C(WORDS+4).
- START outside IDLE: ignored. START with EN=0: ignored.
- Ordering: share writes occur in strictly ascending tile order, exactly WORDS writes per transfer.

Optional Feature:
- Macro WB_CHECKSUM_EN.
- Defined:
  - Adds output CHECKSUM [DATA_W], reset 0, cleared on accepted START.
  - CHECKSUM accumulates the sum modulo 2^DATA_W of every share_wdata actually written.
  - Stable and valid from the DONE cycle until the next accepted START.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Basic transfer:
  - Stimulus: WORDS=31, OADDR=0x0100, output buffer word[i]=3*i, START at C0, EN=1.
  - Response: 31 writes to 0x0100..0x011E with data 0..90; first write C3, DONE at C34 only; BUSY low at C35.
- Stall mid-stream:
  - Stimulus: EN=0 for 5 cycles after 10 reads.
  - Response: no new reads during the stall; in-flight word 9 still written; all 31 words written exactly once, in order; DONE delayed by 5 cycles (C39).
- Address wrap:
  - Stimulus: OADDR=0x1FFE.
  - Response: writes go to 0x1FFE, 0x1FFF, 0x0000 ... 0x001C.
- Ignored START:
  - Stimulus: START pulsed during STREAM with OADDR=0x0500.
  - Response: base unchanged, no restart, single DONE.
- Reset mid-operation:
  - Stimulus: RESET asserted at C15, released at C17.
  - Response: all outputs at reset values in the cycle after assertion, STATE=0, no DONE; a new START then completes a normal transfer.
- Checksum (WB_CHECKSUM_EN defined):
  - Stimulus: word[i]=0x1000+i.
  - Response: CHECKSUM = (31*0x1000+465) mod 2^16 = 0xF1D1 at DONE.

Source files
------------

// File: rtl/output_share_writeback.sv
// Writeback engine: drains one result tile from the output buffer SRAM
// into the shared SRAM starting at base address OADDR, one word per cycle.
// Optional macro WB_CHECKSUM_EN adds a CHECKSUM output (sum of written data).
// Ports:
//   CLK, RESET (async, active-high), EN (global enable), START, OADDR (base)
//   STATE/BUSY/DONE             : status
//   output_* (cen/wen/ren/addr) : output buffer read port, output_rdata in
//   share_* (cen/wen/ren/addr/wdata) : share memory write port
//   CHECKSUM (WB_CHECKSUM_EN only)
module output_share_writeback #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int WORDS  = 31
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic              START,
    input  logic [ADDR_W-1:0] OADDR,
    output logic [2:0]        STATE,
    output logic              BUSY,
    output logic              DONE,
    output logic              output_cen,
    output logic              output_wen,
    output logic              output_ren,
    output logic [ADDR_W-1:0] output_addr,
    input  logic [DATA_W-1:0] output_rdata,
    output logic              share_cen,
    output logic              share_wen,
    output logic              share_ren,
    output logic [ADDR_W-1:0] share_addr,
    output logic [DATA_W-1:0] share_wdata
`ifdef WB_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] CHECKSUM
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_FLUSH  = 3'd2,
        S_FINISH = 3'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              issue;
    logic              accept;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] base;

    assign STATE      = state;
    assign output_wen = 1'b1;
    assign share_ren  = 1'b0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Read issue is decided here so the registered read strobe appears in
    // the cycle right after the deciding edge (accepting START issues read 0).
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        accept   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (START && EN) begin
                    accept   = 1'b1;
                    issue    = 1'b1;
                    state_nx = S_STREAM;
                end
            end
            S_STREAM: begin
                if (rd_cnt == ADDR_W'(WORDS)) state_nx = S_FLUSH;
                else if (EN)                  issue    = 1'b1;
            end
            S_FLUSH: begin
                // last read returned and its write is on the bus now
                if (!rd_pend && output_cen) state_nx = S_FINISH;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            output_cen  <= 1'b1;
            output_ren  <= 1'b0;
            output_addr <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            base        <= '0;
            rd_pend     <= 1'b0;
            share_cen   <= 1'b1;
            share_wen   <= 1'b1;
            share_addr  <= '0;
            share_wdata <= '0;
        end else begin
            BUSY       <= (state_nx != S_IDLE);
            DONE       <= (state_nx == S_FINISH);
            output_cen <= ~issue;
            output_ren <= issue;
            if (accept) begin
                base   <= OADDR;
                wr_cnt <= '0;
            end
            if (issue) begin
                output_addr <= accept ? '0 : rd_cnt;
                rd_cnt      <= accept ? ADDR_W'(1) : rd_cnt + ADDR_W'(1);
            end
            // rdata is valid the cycle after a read is presented; it is
            // captured whatever EN does so a stall never loses a word
            rd_pend   <= ~output_cen;
            share_cen <= ~rd_pend;
            share_wen <= ~rd_pend;
            if (rd_pend) begin
                share_addr  <= base + wr_cnt;
                share_wdata <= output_rdata;
                wr_cnt      <= wr_cnt + ADDR_W'(1);
            end
        end
    end

`ifdef WB_CHECKSUM_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)        CHECKSUM <= '0;
        else if (accept)  CHECKSUM <= '0;
        else if (rd_pend) CHECKSUM <= CHECKSUM + output_rdata;
    end
`endif

endmodule

// File: tb/tb_output_share_writeback.sv
// Directed table-driven bench for output_share_writeback.
// Checks latency, ordering, stall, wrap, ignored START and reset abort.
module tb_output_share_writeback;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam int NW = 31;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          EN;
    logic          START;
    logic [AW-1:0] OADDR;
    logic [2:0]    STATE;
    logic          BUSY;
    logic          DONE;
    logic          output_cen;
    logic          output_wen;
    logic          output_ren;
    logic [AW-1:0] output_addr;
    logic [DW-1:0] output_rdata;
    logic          share_cen;
    logic          share_wen;
    logic          share_ren;
    logic [AW-1:0] share_addr;
    logic [DW-1:0] share_wdata;
`ifdef WB_CHECKSUM_EN
    logic [DW-1:0] CHECKSUM;
`endif

    output_share_writeback #(.ADDR_W(AW), .DATA_W(DW), .WORDS(NW)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .START(START), .OADDR(OADDR),
        .STATE(STATE), .BUSY(BUSY), .DONE(DONE),
        .output_cen(output_cen), .output_wen(output_wen),
        .output_ren(output_ren), .output_addr(output_addr),
        .output_rdata(output_rdata),
        .share_cen(share_cen), .share_wen(share_wen), .share_ren(share_ren),
        .share_addr(share_addr), .share_wdata(share_wdata)
`ifdef WB_CHECKSUM_EN
        , .CHECKSUM(CHECKSUM)
`endif
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] mem [0:63];
    always @(posedge CLK) begin
        if (!output_cen) output_rdata <= mem[output_addr[5:0]];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int            t0;
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];
    int            wc_q [$];
    int            rc_q [$];
    int            dc_q [$];

    always @(negedge CLK) begin
        if (!share_cen && !share_wen) begin
            wa_q.push_back(share_addr);
            wd_q.push_back(share_wdata);
            wc_q.push_back(cyc - t0);
        end
        if (!output_cen && output_ren) rc_q.push_back(cyc - t0);
        if (DONE) dc_q.push_back(cyc - t0);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({STATE, BUSY, DONE, output_cen, output_wen, output_ren,
                    output_addr, share_cen, share_wen, share_ren,
                    share_addr, share_wdata});
    endfunction

    localparam logic [63:0] RST_OUTS =
        64'({3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 13'd0,
             1'b1, 1'b1, 1'b0, 13'd0, 16'd0});

    typedef struct {
        string         nm;
        logic [AW-1:0] oaddr;
        logic [DW-1:0] off;
        logic [DW-1:0] mul;
        bit            stall;
        bit            mid;
        int            done;
    } vec_t;

    task automatic clr_q();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        rc_q.delete(); dc_q.delete();
    endtask

    task automatic run(input vec_t v);
        int            bad;
        logic [DW-1:0] sum;
        sum = '0;
        for (int i = 0; i < 64; i++) mem[i] = DW'(v.off + v.mul * DW'(i));
        for (int i = 0; i < NW; i++) sum = sum + mem[i];
        @(negedge CLK);
        clr_q();
        t0    = cyc;
        START = 1'b1;
        OADDR = v.oaddr;
        EN    = 1'b1;
        for (int k = 1; k < 46; k++) begin
            @(negedge CLK);
            START = v.mid && (k == 5);
            OADDR = (v.mid && k == 5) ? 13'h0500 : v.oaddr;
            EN    = !(v.stall && k >= 10 && k < 15);
            if (k == 1) chk({v.nm, " busy_c1"}, 64'(BUSY), 64'd1);
`ifdef WB_CHECKSUM_EN
            if (k == v.done) chk({v.nm, " checksum"}, 64'(CHECKSUM), 64'(sum));
`endif
            if (k == v.done + 1) begin
                chk({v.nm, " idle_after_done"}, 64'({STATE, BUSY}), 64'd0);
            end
        end
        START = 1'b0;
        EN    = 1'b1;
        chk({v.nm, " write_count"}, 64'(wa_q.size()), 64'(NW));
        bad = 0;
        for (int i = 0; i < wa_q.size() && i < NW; i++) begin
            if (wa_q[i] !== AW'(v.oaddr + AW'(i))) bad++;
            if (wd_q[i] !== DW'(v.off + v.mul * DW'(i))) bad++;
        end
        chk({v.nm, " write_addr_data_errs"}, 64'(bad), 64'd0);
        if (wa_q.size() > 0) begin
            chk({v.nm, " first_addr"}, 64'(wa_q[0]), 64'(v.oaddr));
            chk({v.nm, " first_wr_cycle"}, 64'(wc_q[0]), 64'd3);
            chk({v.nm, " last_wr_cycle"}, 64'(wc_q[wc_q.size()-1]),
                64'(v.done - 1));
        end
        chk({v.nm, " read_count"}, 64'(rc_q.size()), 64'(NW));
        bad = 0;
        foreach (rc_q[i]) if (rc_q[i] >= 11 && rc_q[i] <= 15) bad++;
        if (v.stall) chk({v.nm, " reads_in_stall"}, 64'(bad), 64'd0);
        chk({v.nm, " done_count"}, 64'(dc_q.size()), 64'd1);
        if (dc_q.size() > 0)
            chk({v.nm, " done_cycle"}, 64'(dc_q[0]), 64'(v.done));
    endtask

    vec_t vt [4];

    initial begin
        int late;
        vt[0] = '{"basic",  13'h0100, 16'd0, 16'd3, 1'b0, 1'b0, 34};
        vt[1] = '{"stall",  13'h0100, 16'd0, 16'd3, 1'b1, 1'b0, 39};
        vt[2] = '{"wrap",   13'h1FFE, 16'd0, 16'd3, 1'b0, 1'b0, 34};
        vt[3] = '{"ignore", 13'h0200, 16'd7, 16'd5, 1'b0, 1'b1, 34};
        t0    = 0;
        RESET = 1'b1;
        EN    = 1'b0;
        START = 1'b0;
        OADDR = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (2) @(negedge CLK);
        chk("reset_outputs", outs(), RST_OUTS);
        @(negedge CLK);
        RESET = 1'b0;
        EN    = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("start_with_en0_ignored", 64'({STATE, BUSY}), 64'd0);
        EN = 1'b1;

        for (int n = 0; n < 4; n++) run(vt[n]);

        // reset in the middle of a transfer
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);
        @(negedge CLK);
        clr_q();
        t0    = cyc;
        START = 1'b1;
        OADDR = 13'h0300;
        for (int k = 1; k < 15; k++) begin
            @(negedge CLK);
            START = 1'b0;
        end
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("rst_mid_immediate", outs(), RST_OUTS);
        @(negedge CLK);
        chk("rst_mid_hold", outs(), RST_OUTS);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (40) @(negedge CLK);
        chk("rst_mid_no_done", 64'(dc_q.size()), 64'd0);
        late = 0;
        foreach (wc_q[i]) if (wc_q[i] >= 16) late++;
        chk("rst_mid_no_late_writes", 64'(late), 64'd0);
        chk("rst_mid_idle", 64'({STATE, BUSY}), 64'd0);
        run(vt[0]);

`ifdef WB_CHECKSUM_EN
        begin
            vec_t ck;
            ck = '{"cksum", 13'h0040, 16'h1000, 16'd1, 1'b0, 1'b0, 34};
            run(ck);
            chk("checksum_const", 64'(CHECKSUM), 64'hF1D1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
